// File: rtl/si_link_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | si_link_pkg                                                          |
// | Shared constants, header field offsets and parser state encoding     |
// | used by the FPGA-link stream stages.                                 |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package si_link_pkg;

  localparam logic [31:0] LINK_MAGIC     = 32'h5349_5454;
  localparam logic [7:0]  LINK_VERSION   = 8'd1;
  localparam logic [7:0]  TYPE_TIME_TAGS = 8'h01;

  // Bit offsets of the header fields inside the first 128-bit word
  localparam int HDR_MAGIC_LSB   = 0;
  localparam int HDR_VERSION_LSB = 32;
  localparam int HDR_TYPE_LSB    = 40;
  localparam int HDR_SEQ_LSB     = 64;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } parser_state_t;

endpackage
`default_nettype wire

// File: rtl/si_header_parser_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | si_header_parser_if                                                  |
// | AXI-Stream bundle (valid/ready/data/keep/last) with master and slave |
// | views.                                                               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface si_header_parser_if #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/si_axis_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | si_axis_skid_buffer                                                  |
// | Two-entry registered AXI-Stream buffer. Input ready comes straight   |
// | from a flop, so downstream ready never reaches upstream in the same  |
// | cycle; full throughput while the output is not stalled.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module si_axis_skid_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  in_valid,
  output      logic                  in_ready,
  input  wire logic [DATA_WIDTH-1:0] in_data,
  input  wire logic [KEEP_WIDTH-1:0] in_keep,
  input  wire logic                  in_last,
  output      logic                  out_valid,
  input  wire logic                  out_ready,
  output      logic [DATA_WIDTH-1:0] out_data,
  output      logic [KEEP_WIDTH-1:0] out_keep,
  output      logic                  out_last
);

  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [KEEP_WIDTH-1:0] skid_keep;
  logic                  skid_last;
  logic                  out_free;

  // Spare entry empty means we can take one more beat whatever happens downstream
  assign in_ready = !skid_valid;
  assign out_free = !out_valid || out_ready;

  // Occupancy flags: refill the output from the spare entry first, else from the input
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      out_valid  <= skid_valid || in_valid;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  end

  // Data path registers follow the occupancy decisions above; no reset needed
  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid) begin
        out_data <= skid_data;
        out_keep <= skid_keep;
        out_last <= skid_last;
      end else begin
        out_data <= in_data;
        out_keep <= in_keep;
        out_last <= in_last;
      end
    end else if (in_valid && !skid_valid) begin
      skid_data <= in_data;
      skid_keep <= in_keep;
      skid_last <= in_last;
    end
  end

endmodule
`default_nettype wire

// File: rtl/si_header_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | si_header_parser                                                     |
// | Validates the one-word link header, tracks the sequence number,      |
// | strips the header and forwards payload of valid packets through a    |
// | skid stage. Flags lost and invalid packets for statistics.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module si_header_parser
  import si_link_pkg::*;
#(
  parameter int          DATA_WIDTH = 128,
  parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
  parameter logic [31:0] MAGIC      = LINK_MAGIC,
  parameter logic [7:0]  VERSION    = LINK_VERSION
) (
  input  wire logic         clk,
  input  wire logic         rst,
  si_header_parser_if.slave  s_axis,
  si_header_parser_if.master m_axis,
  output      logic         lost_packet,
  output      logic         invalid_packet,
  output      logic [31:0]  last_sequence
);

  parser_state_t state;
  logic          seq_valid;
  logic [31:0]   expected_seq;
  logic [31:0]   hdr_seq;
  logic          header_ok;
  logic          in_fire;
  logic          skid_in_valid;
  logic          skid_in_ready;

  assign hdr_seq = s_axis.tdata[HDR_SEQ_LSB +: 32];

  // A header must match every identity field, be a full word and carry payload
  assign header_ok = (s_axis.tdata[HDR_MAGIC_LSB +: 32]  == MAGIC)
                  && (s_axis.tdata[HDR_VERSION_LSB +: 8] == VERSION)
                  && (s_axis.tdata[HDR_TYPE_LSB +: 8]    == TYPE_TIME_TAGS)
                  && (&s_axis.tkeep)
                  && !s_axis.tlast;

  // Only payload beats touch the skid stage; header and dropped beats are always taken
  assign skid_in_valid  = (state == PAYLOAD) && s_axis.tvalid;
  assign s_axis.tready  = (state == PAYLOAD) ? skid_in_ready : 1'b1;
  assign in_fire        = s_axis.tvalid && s_axis.tready;

  // Discard indication is combinational so it covers the tlast beat too
  assign invalid_packet = ((state == HEADER) && s_axis.tvalid && !header_ok)
                       || (state == DROP);

  // Packet framing FSM plus sequence tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HEADER;
      seq_valid     <= 1'b0;
      expected_seq  <= 32'd0;
      last_sequence <= 32'd0;
      lost_packet   <= 1'b0;
    end else begin
      lost_packet <= 1'b0;
      case (state)
        HEADER: begin
          if (in_fire) begin
            if (header_ok) begin
              state         <= PAYLOAD;
              last_sequence <= hdr_seq;
              expected_seq  <= hdr_seq + 32'd1;
              seq_valid     <= 1'b1;
              lost_packet   <= seq_valid && (hdr_seq != expected_seq);
            end else if (!s_axis.tlast) begin
              state <= DROP;
            end
          end
        end
        PAYLOAD, DROP: begin
          if (in_fire && s_axis.tlast) begin
            state <= HEADER;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

  si_axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (skid_in_valid),
    .in_ready  (skid_in_ready),
    .in_data   (s_axis.tdata),
    .in_keep   (s_axis.tkeep),
    .in_last   (s_axis.tlast),
    .out_valid (m_axis.tvalid),
    .out_ready (m_axis.tready),
    .out_data  (m_axis.tdata),
    .out_keep  (m_axis.tkeep),
    .out_last  (m_axis.tlast)
  );

endmodule
`default_nettype wire

// File: tb/tb_si_header_parser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_si_header_parser                                                  |
// | Directed self-checking bench for the link header parser.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_si_header_parser;
  import si_link_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lost_packet;
  logic        invalid_packet;
  logic [31:0] last_sequence;

  si_header_parser_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) s_if ();
  si_header_parser_if #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) m_if ();

  si_header_parser dut (
    .clk            (clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .lost_packet    (lost_packet),
    .invalid_packet (invalid_packet),
    .last_sequence  (last_sequence)
  );

  always #5 clk = ~clk;

  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  bit           bp = 1'b0;
  logic [144:0] rx_q[$];
  logic [144:0] exp_q[$];
  int           lost_cnt = 0;
  int           lost_cyc = -1;
  int           pkt_inv = 0;
  int           max_wait = 0;
  int           hs_cyc = 0;
  bit           prev_stall = 1'b0;
  logic [144:0] prev_beat;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Cycle counter used to time the lost_packet pulse
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: capture delivered beats, watch stall stability and loss pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall)
        chk("stall_hold", {m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast}, {1'b1, prev_beat});
      if (m_if.tvalid && m_if.tready)
        rx_q.push_back({m_if.tdata, m_if.tkeep, m_if.tlast});
      if (lost_packet) begin
        lost_cnt++;
        lost_cyc = cyc;
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tdata, m_if.tkeep, m_if.tlast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp) m_if.tready = !m_if.tready;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  function automatic logic [127:0] hdr(input logic [31:0] magic, input logic [7:0] ver,
                                       input logic [7:0] typ, input logic [31:0] seq);
    return {32'hDEAD_BEEF, seq, 16'hABCD, typ, ver, magic};
  endfunction

  task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input bit l,
                           output bit inv, output int waits);
    bit ok;
    ok    = 1'b0;
    waits = 0;
    inv   = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tlast  = l;
    while (!ok && waits <= 100) begin
      @(negedge clk);
      ok  = s_if.tready;
      inv = invalid_packet;
      tick();
      if (!ok) waits++;
    end
    if (!ok) chk("beat_timeout", 0, 1);
    s_if.tvalid = 1'b0;
  endtask

  // Send header plus n payload words; forwarded payload goes to the expected queue
  task automatic send_pkt(input logic [127:0] h, input int n, input logic [31:0] tag, input bit fwd);
    bit           inv;
    int           w;
    logic [127:0] d;
    logic [15:0]  k;
    bit           l;
    pkt_inv  = 0;
    max_wait = 0;
    send_beat(h, 16'hFFFF, (n == 0), inv, w);
    hs_cyc = cyc;
    if (inv) pkt_inv++;
    if (w > max_wait) max_wait = w;
    for (int i = 0; i < n; i++) begin
      d = {tag, 64'h0, i[31:0]};
      k = (i == n - 1) ? 16'h00FF : 16'hFFFF;
      l = (i == n - 1);
      send_beat(d, k, l, inv, w);
      if (inv) pkt_inv++;
      if (w > max_wait) max_wait = w;
      if (fwd) exp_q.push_back({d, k, l});
    end
  endtask

  task automatic check_rx(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int hs8;
    int waits;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_lost", lost_packet, 0);
    chk("rst_last_seq", last_sequence, 0);
    chk("rst_s_tready", s_if.tready, 1);
    chk("rst_invalid", invalid_packet, 0);
    tick();

    // Valid packet, seq 5, three payload words
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd5), 3, 32'hA1, 1);
    drain(4);
    check_rx("pkt5");
    chk("pkt5_invalid", pkt_inv, 0);
    chk("pkt5_lost", lost_cnt, 0);
    chk("pkt5_last_seq", last_sequence, 5);

    // Sequence gap: 6 then 8
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd6), 2, 32'hB6, 1);
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd8), 2, 32'hB8, 1);
    hs8 = hs_cyc;
    drain(4);
    chk("gap_lost_cnt", lost_cnt, 1);
    chk("gap_lost_cycle", lost_cyc, hs8);
    chk("gap_last_seq", last_sequence, 8);
    check_rx("gap");

    // Wrap: FFFF_FFFF then 0 is in order
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'hFFFF_FFFF), 1, 32'hC1, 1);
    drain(3);
    lost_cnt = 0;
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd0), 1, 32'hC2, 1);
    drain(3);
    chk("wrap_lost", lost_cnt, 0);
    chk("wrap_last_seq", last_sequence, 0);
    check_rx("wrap");

    // Bad magic packet is dropped, then a good one flows
    send_pkt(hdr(32'h0, 8'd1, 8'h01, 32'd9), 4, 32'hBAD, 0);
    chk("bad_invalid_beats", pkt_inv, 5);
    chk("bad_tready_waits", max_wait, 0);
    chk("bad_last_seq", last_sequence, 0);
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd1), 2, 32'hD1, 1);
    drain(3);
    check_rx("after_bad");
    chk("after_bad_lost", lost_cnt, 0);

    // Header-only packet is invalid and leaves the parser in HEADER
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd77), 0, 32'h0, 0);
    chk("hdr_only_invalid", pkt_inv, 1);
    chk("hdr_only_ready", s_if.tready, 1);
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd2), 1, 32'hE2, 1);
    drain(3);
    check_rx("after_hdr_only");
    chk("hdr_only_last_seq", last_sequence, 2);
    chk("hdr_only_lost", lost_cnt, 0);

    // Backpressure: downstream ready toggles every cycle
    bp = 1'b1;
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd3), 8, 32'hF3, 1);
    drain(20);
    bp = 1'b0;
    m_if.tready = 1'b1;
    drain(3);
    check_rx("bp");

    // Reset in the middle of a payload under backpressure
    bp = 1'b1;
    send_beat(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd4), 16'hFFFF, 1'b0, prev_stall, waits);
    for (int i = 0; i < 3; i++)
      send_beat({32'h44, 64'h0, i[31:0]}, 16'hFFFF, 1'b0, prev_stall, waits);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_m_tvalid", m_if.tvalid, 0);
    chk("midrst_last_seq", last_sequence, 0);
    rst = 1'b0;
    bp = 1'b0;
    m_if.tready = 1'b1;
    rx_q.delete();
    exp_q.delete();
    lost_cnt = 0;
    tick();

    // First packet after reset never flags loss
    send_pkt(hdr(LINK_MAGIC, 8'd1, 8'h01, 32'd7), 2, 32'h77, 1);
    drain(4);
    chk("post_rst_lost", lost_cnt, 0);
    chk("post_rst_last_seq", last_sequence, 7);
    check_rx("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/si_header_parser.md
Name: si_header_parser

Overview:
- Upstream neighbour of the statistics block. Receives the 128-bit-word AXI-Stream of FPGA-link packets. Each packet's first word is a 128-bit header.
- Validates the header and tracks the sequence number.
- Strips the header and forwards only the payload of valid packets downstream, through a registered skid stage.
- Produces the lost_packet and invalid_packet indications that the statistics block consumes.

Parameters:
- DATA_WIDTH, 128, stream data width; fixed at 128, since the header occupies exactly one word.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- MAGIC, 32'h5349_5454, required header magic.
- VERSION, 8'd1, required header version.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tlast  in  1  last beat of packet
- m_axis_tvalid  out  1  payload valid
- m_axis_tready  in  1  payload ready
- m_axis_tdata  out  DATA_WIDTH  payload data
- m_axis_tkeep  out  KEEP_WIDTH  payload byte enables
- m_axis_tlast  out  1  last payload beat
- lost_packet  out  1  one-cycle pulse on a sequence gap
- invalid_packet  out  1  current packet is being discarded; valid on every input beat, including tlast
- last_sequence  out  32  sequence number of the last valid header

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state=HEADER, seq_valid=0, expected_seq=0, last_sequence=0.
  - lost_packet=0, m_axis_tvalid=0; skid stage emptied.
- Header fields (little-endian bit indices):
  - [31:0] magic
  - [39:32] version
  - [47:40] type, which must be 8'h01 (time tags)
  - [63:48] reserved, ignored
  - [95:64] sequence
  - [127:96] reserved, ignored
- header_ok, evaluated combinationally on a HEADER-state beat, requires all of:
  - magic==MAGIC, version==VERSION, type==1
  - tkeep all ones
  - tlast==0 (header-only packets are invalid)
- State HEADER:
  - s_axis_tready=1; the header beat is never forwarded.
  - On handshake with header_ok: go to PAYLOAD; last_sequence<=sequence; expected_seq<=sequence+1 (wraps mod 2^32); seq_valid<=1.
  - lost_packet pulses on the following cycle iff seq_valid && sequence!=expected_seq.
  - On handshake with !header_ok: go to DROP if tlast==0, else stay in HEADER. Sequence state is unchanged.
- State PAYLOAD:
  - s_axis_tready = skid-stage input ready.
  - Beats are forwarded unmodified (tdata, tkeep, tlast).
  - On a handshake with tlast: go to HEADER.
- State DROP:
  - s_axis_tready=1; beats are discarded.
  - On a handshake with tlast: go to HEADER.
- invalid_packet = (state==HEADER && s_axis_tvalid && !header_ok) || state==DROP. It is combinational, so it is high on the tlast beat of every discarded packet.
- Skid stage:
  - Two-entry registered buffer. Input ready is registered (high when the spare entry is empty).
  - Full throughput when m_axis_tready is held high; no combinational path from m_axis_tready to s_axis_tready.
  - Payload latency is 1 cycle from input handshake to m_axis_tvalid.
- Backpressure:
  - Once asserted, m_axis_tvalid and its data are held stable until m_axis_tready.
  - Header and DROP beats are accepted regardless of m_axis_tready.
- Sequence wrap: 32'hFFFF_FFFF followed by 0 is in-order; no lost_packet.
- The first valid header after reset never flags loss.
- Reset mid-packet: everything returns to the reset state, and the next input beat is treated as a header. Upstream's remaining beats of that packet are therefore normally rejected as invalid. This is accepted behaviour.
- lost_packet and invalid_packet are never suppressed by backpressure.

Decomposition:
- Shared package si_link_pkg:
  - MAGIC/VERSION/type constants
  - header field bit-offset localparams
  - parser_state_t enum {HEADER, PAYLOAD, DROP}
- One natural sub-module: si_axis_skid_buffer (DATA_WIDTH, KEEP_WIDTH), reusable on other link stages.

Test Plan:
- Valid packet: header with seq=5 plus 3 payload words, m_axis_tready=1 -> 3 beats out, tlast on the 3rd; invalid_packet=0; lost_packet=0; last_sequence=5.
- Sequence gap: packets with seq 5, 6, 8 -> exactly one lost_packet pulse, one cycle after the seq-8 header; all three payloads forwarded.
- Sequence wrap: seq 32'hFFFF_FFFF then 0 -> no lost_packet; last_sequence=0.
- Bad magic (32'h0) with 4 payload words -> no output beats; s_axis_tready=1 throughout; invalid_packet high on all 5 beats including tlast; the next valid packet is forwarded normally.
- Header-only packet (tlast on the header) -> invalid_packet=1 on that beat, state remains HEADER, no output.
- Backpressure: 8-word payload with m_axis_tready toggling 1/0 every cycle -> all 8 beats delivered in order, none duplicated; m_axis data stable while stalled; rst asserted mid-payload -> m_axis_tvalid=0 next cycle.
